fetch_sequencer: RTL and testbench

//  Multi-cycle fetch/execute sequencer driving the ProgramCounter load/PCsrc controls.

---
 rtl/fetch_sequencer.sv | 152 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Multi-cycle fetch/execute sequencer. It issues an instruction-memory
//   request at the current PC, waits for the response, hands the word to
//   the execute stage and then commits the PC update (PC+4 or PC+ImmExt)
//   through the ProgramCounter load/PCsrc controls.
//
// Parameters
//   TIMEOUT  max cycles spent waiting for a response before erroring (>=2)
//   CNT_W    width of the retired-instruction counter
//
// Ports
//   i_clk, i_areset        clock (rising edge), async reset active low
//   i_run, i_halt          level controls: start/continue, stop after commit
//   i_clear_err            leave ERROR, return to IDLE
//   i_pc                   current PC from the ProgramCounter
//   o_imem_req_valid/addr  fetch request (addr = pc while valid, else 0)
//   i_imem_req_ready       memory accepts request
//   i_imem_rsp_valid/data  fetched instruction
//   o_instr, o_instr_valid latched instruction, one-cycle "new" pulse
//   i_exec_done            execute stage finished current instruction
//   i_branch_taken         sampled with exec_done: select PC+ImmExt
//   o_pc_load, o_pc_src    ProgramCounter controls, one cycle per instr
//   o_busy                 not IDLE and not ERROR
//   o_fetch_err            high while in ERROR
//   o_retired              committed instruction count (wraps)
module fetch_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_areset,
  input  logic             i_run,
  input  logic             i_halt,
  input  logic             i_clear_err,
  input  logic [31:0]      i_pc,
  output logic             o_imem_req_valid,
  output logic [31:0]      o_imem_req_addr,
  input  logic             i_imem_req_ready,
  input  logic             i_imem_rsp_valid,
  input  logic [31:0]      i_imem_rsp_data,
  output logic [31:0]      o_instr,
  output logic             o_instr_valid,
  input  logic             i_exec_done,
  input  logic             i_branch_taken,
  output logic             o_pc_load,
  output logic             o_pc_src,
  output logic             o_busy,
  output logic             o_fetch_err,
  output logic [CNT_W-1:0] o_retired
);

  localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t             r_state, w_nxt;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [31:0]        r_instr;
  logic               r_instr_valid;
  logic [CNT_W-1:0]   r_retired;

  logic               w_accept;   // request handshake completes this cycle
  logic               w_latch;    // response captured this cycle
  logic               w_retire;   // instruction commits this cycle

  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      r_state       <= S_IDLE;
      r_wcnt        <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_retired     <= '0;
    end else begin
      r_state       <= w_nxt;
      r_instr_valid <= w_latch;
      if (w_latch)
        r_instr <= i_imem_rsp_data;
      if (w_accept)
        r_wcnt <= '0;
      else if (r_state == S_WAIT)
        r_wcnt <= r_wcnt + WCNT_W'(1);
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_nxt            = r_state;
    w_accept         = 1'b0;
    w_latch          = 1'b0;
    w_retire         = 1'b0;
    o_imem_req_valid = 1'b0;
    o_imem_req_addr  = '0;
    o_pc_load        = 1'b0;
    o_pc_src         = 1'b0;
    o_fetch_err      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_run && !i_halt)
          w_nxt = S_FETCH;
      end
      S_FETCH: begin
        // A misaligned PC never reaches the memory port.
        if (i_pc[1:0] != 2'b00) begin
          w_nxt = S_ERR;
        end else begin
          o_imem_req_valid = 1'b1;
          o_imem_req_addr  = i_pc;
          if (i_imem_req_ready) begin
            w_accept = 1'b1;
            w_nxt    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A response on the last allowed cycle still wins over the timeout.
        if (i_imem_rsp_valid) begin
          w_latch = 1'b1;
          w_nxt   = S_EXEC;
        end else if (r_wcnt == WCNT_W'(TIMEOUT - 1)) begin
          w_nxt = S_ERR;
        end
      end
      S_EXEC: begin
        if (i_exec_done) begin
          o_pc_load = 1'b1;
          o_pc_src  = i_branch_taken;
          w_retire  = 1'b1;
          w_nxt     = (i_halt || !i_run) ? S_IDLE : S_FETCH;
        end
      end
      S_ERR: begin
        o_fetch_err = 1'b1;
        if (i_clear_err)
          w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  assign o_busy        = (r_state != S_IDLE) && (r_state != S_ERR);
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             areset, run, halt, clear_err;
  logic [31:0]      pc;
  logic             req_valid, req_ready, rsp_valid;
  logic [31:0]      req_addr, rsp_data, instr;
  logic             instr_valid, exec_done, branch_taken;
  logic             pc_load, pc_src, busy, fetch_err;
  logic [CNT_W-1:0] retired;

  // ProgramCounter stand-in, with an override to present misaligned PCs
  logic [31:0] pc_reg, imm, pc_ovr_val;
  logic        pc_ovr;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_pc;
  int          exp_ret;

  always #5 clk = ~clk;

  assign pc = pc_ovr ? pc_ovr_val : pc_reg;

  always @(posedge clk or negedge areset)
    if (!areset)      pc_reg <= 32'd0;
    else if (pc_load) pc_reg <= pc_src ? pc_reg + imm : pc_reg + 32'd4;

  fetch_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_areset(areset), .i_run(run), .i_halt(halt),
    .i_clear_err(clear_err), .i_pc(pc),
    .o_imem_req_valid(req_valid), .o_imem_req_addr(req_addr),
    .i_imem_req_ready(req_ready), .i_imem_rsp_valid(rsp_valid),
    .i_imem_rsp_data(rsp_data), .o_instr(instr), .o_instr_valid(instr_valid),
    .i_exec_done(exec_done), .i_branch_taken(branch_taken),
    .o_pc_load(pc_load), .o_pc_src(pc_src), .o_busy(busy),
    .o_fetch_err(fetch_err), .o_retired(retired)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change at posedge+1, outputs are sampled at posedge+2.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_vld"},   {31'd0, req_valid}, 0);
    chk({tag, "_addr"},  req_addr, 0);
    chk({tag, "_pcld"},  {31'd0, pc_load}, 0);
    chk({tag, "_pcsrc"}, {31'd0, pc_src}, 0);
    chk({tag, "_busy"},  {31'd0, busy}, 0);
  endtask

  // Wait (bounded) for a request, then accept it after 'hold' stalled cycles.
  task automatic issue(input int hold);
    int n = 0;
    req_ready = 0; rsp_valid = 0; exec_done = 0; branch_taken = 0;
    #1;
    while (!req_valid && n < 10) begin tick(); #1; n++; end
    chk("req_seen", {31'd0, req_valid}, 1);
    chk("req_addr", req_addr, exp_pc);
    for (int k = 0; k < hold; k++) begin
      tick(); #1;
      chk("hold_vld",  {31'd0, req_valid}, 1);
      chk("hold_addr", req_addr, exp_pc);
    end
    req_ready = 1;
    tick();
    req_ready = 0;
    #1;
    chk("wait_vld",  {31'd0, req_valid}, 0);
    chk("wait_busy", {31'd0, busy}, 1);
  endtask

  // One complete instruction: request, response after 'lat' empty WAIT
  // cycles, exec_done after 'ex' EXEC cycles, then commit.
  // stop: 0 keep running, 1 assert halt, 2 drop run.
  task automatic fetch_one(input int hold, input int lat, input int ex,
                           input logic br, input logic [31:0] immv,
                           input logic [31:0] data, input int stop);
    issue(hold);
    for (int k = 0; k < lat; k++) begin
      chk("wait_err", {31'd0, fetch_err}, 0);
      tick(); #1;
    end
    rsp_valid = 1; rsp_data = data;
    tick();
    rsp_valid = 0; rsp_data = $urandom;
    #1;
    chk("ivld_first", {31'd0, instr_valid}, 1);
    chk("instr",      instr, data);
    chk("err_exec",   {31'd0, fetch_err}, 0);
    for (int k = 0; k < ex; k++) begin
      chk("pcld_idle", {31'd0, pc_load}, 0);
      tick(); #1;
      chk("ivld_later", {31'd0, instr_valid}, 0);
    end
    exec_done = 1; branch_taken = br; imm = immv;
    if (stop == 1) halt = 1;
    if (stop == 2) run = 0;
    #1;
    chk("pc_load", {31'd0, pc_load}, 1);
    chk("pc_src",  {31'd0, pc_src}, {31'd0, br});
    chk("ret_pre", {28'd0, retired}, exp_ret);
    tick();
    exec_done = 0; branch_taken = 0;
    exp_pc  = br ? exp_pc + immv : exp_pc + 32'd4;
    exp_ret = (exp_ret + 1) % (1 << CNT_W);
    #1;
    chk("ret_post",  {28'd0, retired}, exp_ret);
    chk("pcld_once", {31'd0, pc_load}, 0);
    chk("pc_value",  pc, exp_pc);
    if (stop != 0) begin
      chk("stop_busy", {31'd0, busy}, 0);
      tick(); #1;
      chk_quiet("stopped");
      halt = 0; run = 1;
    end
  endtask

  initial begin
    int hold, lat, ex, stop;
    logic br;
    areset = 0; run = 0; halt = 0; clear_err = 0;
    req_ready = 0; rsp_valid = 0; rsp_data = 0;
    exec_done = 0; branch_taken = 0; imm = 0;
    pc_ovr = 0; pc_ovr_val = 0;
    exp_pc = 0; exp_ret = 0;
    #1;
    chk_quiet("rst");
    chk("rst_err",   {31'd0, fetch_err}, 0);
    chk("rst_ivld",  {31'd0, instr_valid}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_ret",   {28'd0, retired}, 0);
    tick(); tick();
    areset = 1;
    tick();
    run = 1;

    // basic: response two cycles after acceptance
    fetch_one(0, 1, 0, 1'b0, 32'd0, 32'h00500093, 0);
    // branch at pc=4 with ImmExt=0x10 -> next request at 0x14
    fetch_one(0, 0, 1, 1'b1, 32'h10, $urandom, 0);
    // backpressure for 5 cycles, halt with exec_done
    fetch_one(5, 0, 2, 1'b0, 32'd0, $urandom, 1);
    // response on the last allowed cycle still wins
    fetch_one(0, TIMEOUT - 1, 0, 1'b0, 32'd0, $urandom, 0);

    // timeout: TIMEOUT WAIT cycles with no response
    issue(0);
    for (int c = 0; c < TIMEOUT; c++) begin
      chk("to_noerr", {31'd0, fetch_err}, 0);
      chk("to_pcld",  {31'd0, pc_load}, 0);
      tick(); #1;
    end
    chk("to_err",  {31'd0, fetch_err}, 1);
    chk("to_busy", {31'd0, busy}, 0);
    rsp_valid = 1; exec_done = 1;
    tick(); rsp_valid = 0; exec_done = 0; #1;
    chk("err_sticky", {31'd0, fetch_err}, 1);
    chk("err_pcld",   {31'd0, pc_load}, 0);
    clear_err = 1; run = 0;
    tick(); clear_err = 0; #1;
    chk("clr_err",  {31'd0, fetch_err}, 0);
    chk("clr_busy", {31'd0, busy}, 0);
    run = 1;
    fetch_one(1, 2, 0, 1'b0, 32'd0, $urandom, 0);

    // misaligned PC: error without ever requesting
    fetch_one(0, 0, 0, 1'b0, 32'd0, $urandom, 2);
    pc_ovr = 1; pc_ovr_val = exp_pc | 32'd2;
    tick(); #1;
    chk("mis_busy", {31'd0, busy}, 1);
    chk("mis_vld",  {31'd0, req_valid}, 0);
    tick(); #1;
    chk("mis_err",  {31'd0, fetch_err}, 1);
    chk("mis_vld2", {31'd0, req_valid}, 0);
    clear_err = 1; run = 0; pc_ovr = 0;
    tick(); clear_err = 0; run = 1;

    // randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      hold = $urandom_range(0, 3);
      lat  = $urandom_range(0, TIMEOUT - 1);
      ex   = $urandom_range(0, 3);
      br   = $urandom_range(0, 1);
      stop = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      fetch_one(hold, lat, ex, br, {$urandom_range(0, 15), 2'b00}, $urandom, stop);
    end

    // reset while in EXEC
    issue(0);
    rsp_valid = 1; rsp_data = 32'hdeadbeef;
    tick(); rsp_valid = 0;
    areset = 0; #1;
    chk_quiet("arst");
    chk("arst_ivld",  {31'd0, instr_valid}, 0);
    chk("arst_instr", instr, 0);
    chk("arst_ret",   {28'd0, retired}, 0);
    chk("arst_pc",    pc, 0);
    tick(); areset = 1;
    exp_pc = 0; exp_ret = 0;
    fetch_one(0, 0, 0, 1'b0, 32'd0, $urandom, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end
endmodule
